// File: rtl/cache_refill_arbiter_pkg.sv
// Shared FSM encoding and width helpers for the cache refill arbiter.
package cache_refill_pkg;

  typedef logic [2:0] State;

  localparam State S_IDLE  = 3'd0;
  localparam State S_REQ   = 3'd1;
  localparam State S_WAIT  = 3'd2;
  localparam State S_BCAST = 3'd3;
  localparam State S_HOLD  = 3'd4;

  // A line address drops the word-in-line offset bits from the word address.
  function automatic int line_aw(input int addr_in_width, input int block_width_bits);
    return addr_in_width - block_width_bits;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Cache-side request/broadcast bus and memory line-fetch port of the refill arbiter.
interface cache_refill_arbiter_if
  import cache_refill_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LINE_AW = line_aw(20, 5),
  parameter int LINE_W  = 5 * 32
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*LINE_AW-1:0] req_addr;
  logic [N_REQ-1:0]         req_ready;
  logic [LINE_AW-1:0]       addr_broadcast;
  logic                     addr_broadcast_valid;
  logic [LINE_W-1:0]        line_data;
  logic                     mem_req_valid;
  logic [LINE_AW-1:0]       mem_req_addr;
  logic                     mem_req_ready;
  logic                     mem_rsp_valid;
  logic [LINE_W-1:0]        mem_rsp_data;

  modport master (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, addr_broadcast, addr_broadcast_valid, line_data,
           mem_req_valid, mem_req_addr
  );

  modport slave (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, addr_broadcast, addr_broadcast_valid, line_data,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/cache_refill_arbiter_rr.sv
// Round-robin picker: search starts just after the last granted index and wraps.
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // Walk the search order backwards so the candidate closest to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates cache miss requests onto one memory line-fetch port and broadcasts each returned line.
module cache_refill_arbiter
  import cache_refill_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int DWIDTH           = 5,
  parameter int BLOCK_WIDTH_BITS = 5,
  parameter int ADDR_IN_WIDTH    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_refill_arbiter_if.master bus
);
  localparam int LINE_AW = line_aw(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS);
  localparam int LINE_W  = DWIDTH * (2 ** BLOCK_WIDTH_BITS);
  localparam int IW      = $clog2(N_REQ);

  State               state;
  logic [IW-1:0]      grant_q;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic               advance;
  logic [LINE_AW-1:0] addr_q;
  logic [LINE_AW-1:0] sel_addr;
  logic [LINE_W-1:0]  line_q;

  assign advance = (state == S_IDLE) && grant_valid;

  round_robin_arbiter #(.N(N_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .advance     (advance),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IW'(i)) sel_addr = bus.req_addr[i*LINE_AW +: LINE_AW];
    end
  end

  // The request is captured at grant; later changes on req_valid/req_addr do not affect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            grant_q <= grant_idx;
            addr_q  <= sel_addr;
            state   <= S_REQ;
          end
        end
        S_REQ:   if (bus.mem_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            line_q <= bus.mem_rsp_data;
            state  <= S_BCAST;
          end
        end
        S_BCAST: state <= S_HOLD;
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output comes straight from registers or a state decode.
  always_comb begin
    bus.req_ready = '0;
    if (state == S_BCAST) bus.req_ready[grant_q] = 1'b1;
  end

  assign bus.addr_broadcast       = addr_q;
  assign bus.addr_broadcast_valid = (state == S_BCAST);
  assign bus.line_data            = line_q;
  assign bus.mem_req_valid        = (state == S_REQ);
  assign bus.mem_req_addr         = addr_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed scoreboard bench for cache_refill_arbiter with a configurable memory responder.
module tb_cache_refill_arbiter;
  localparam int N  = 4;
  localparam int AW = 15;
  localparam int LW = 160;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    int            cyc;
  } bc_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } mr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_arbiter_if #(.N_REQ(N), .LINE_AW(AW), .LINE_W(LW)) bus ();

  cache_refill_arbiter #(
    .N_REQ(N), .DWIDTH(5), .BLOCK_WIDTH_BITS(5), .ADDR_IN_WIDTH(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bc_t exp_q[$];
  mr_t mq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  int            stall_cfg = 0;
  int            rsp_lat   = 1;
  bit            inj       = 1'b0;
  logic [LW-1:0] inj_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] mkline(input logic [AW-1:0] a);
    return {10{a, 1'b1}};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic push_req(input int idx, input logic [AW-1:0] a, input int mcyc, input int bcyc);
    mr_t m;
    bc_t b;
    m.addr = a;
    m.cyc  = mcyc;
    mq.push_back(m);
    b.idx  = idx;
    b.addr = a;
    b.data = mkline(a);
    b.cyc  = bcyc;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mq.size() != 0) && k < 300) begin
      tick(1);
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d broadcasts and %0d mem requests still pending", exp_q.size(), mq.size());
      exp_q.delete();
      mq.delete();
    end
    tick(3);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req_ready"}, LW'(bus.req_ready), '0);
    chk({tag, "_bcast_valid"}, LW'(bus.addr_broadcast_valid), '0);
    chk({tag, "_bcast_addr"}, LW'(bus.addr_broadcast), '0);
    chk({tag, "_line"}, bus.line_data, '0);
    chk({tag, "_mreq_valid"}, LW'(bus.mem_req_valid), '0);
    chk({tag, "_mreq_addr"}, LW'(bus.mem_req_addr), '0);
  endtask

  // Memory responder: optional ready stall per request, response rsp_lat cycles after acceptance.
  initial begin
    int            stall_left;
    int            rsp_cnt;
    bit            in_req;
    bit            acc;
    logic [AW-1:0] acc_addr;
    logic [AW-1:0] rsp_addr;
    stall_left = 0;
    rsp_cnt    = 0;
    in_req     = 1'b0;
    acc        = 1'b0;
    acc_addr   = '0;
    rsp_addr   = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      if (acc) begin
        rsp_cnt  = rsp_lat;
        rsp_addr = acc_addr;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = mkline(rsp_addr);
        end
      end
      if (inj) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = inj_data;
        inj = 1'b0;
      end
      if (bus.mem_req_valid) begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          bus.mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
        end
      end else begin
        in_req            = 1'b0;
        bus.mem_req_ready = 1'b0;
      end
      acc      = bus.mem_req_valid && bus.mem_req_ready;
      acc_addr = bus.mem_req_addr;
      if (acc) in_req = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a broadcast or a memory request is accepted.
  initial begin
    bc_t           e;
    mr_t           m;
    bit            hold_chk;
    logic [LW-1:0] held;
    bit            pv;
    bit            pacc;
    logic [AW-1:0] paddr;
    hold_chk = 1'b0;
    held     = '0;
    pv       = 1'b0;
    pacc     = 1'b0;
    paddr    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 1'b0;
        pv       = 1'b0;
        pacc     = 1'b0;
        continue;
      end
      if (hold_chk) begin
        chk("hold_line", bus.line_data, held);
        hold_chk = 1'b0;
      end
      if (bus.addr_broadcast_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_bcast: addr %0h req_ready %b with nothing expected", bus.addr_broadcast, bus.req_ready);
        end else begin
          e = exp_q.pop_front();
          chk("req_ready", LW'(bus.req_ready), LW'(4'b0001 << e.idx));
          chk("bcast_addr", LW'(bus.addr_broadcast), LW'(e.addr));
          chk("bcast_line", bus.line_data, e.data);
          if (e.cyc >= 0) chk("bcast_cycle", LW'(cyc), LW'(e.cyc));
          held     = e.data;
          hold_chk = 1'b1;
        end
      end else if (bus.req_ready != '0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_ready: req_ready %b without broadcast strobe", bus.req_ready);
      end
      if (pv && !pacc) begin
        chk("mreq_hold_valid", LW'(bus.mem_req_valid), LW'(1'b1));
        chk("mreq_hold_addr", LW'(bus.mem_req_addr), LW'(paddr));
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (mq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_mreq: addr %0h with nothing expected", bus.mem_req_addr);
        end else begin
          m = mq.pop_front();
          chk("mreq_addr", LW'(bus.mem_req_addr), LW'(m.addr));
          if (m.cyc >= 0) chk("mreq_cycle", LW'(cyc), LW'(m.cyc));
        end
      end
      pv    = bus.mem_req_valid;
      pacc  = bus.mem_req_valid && bus.mem_req_ready;
      paddr = bus.mem_req_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.req_valid = '0;
    bus.req_addr  = '0;

    // Reset values while rst is held.
    tick(2);
    @(negedge clk);
    chk_idle_zero("reset");
    tick(1);
    rst = 1'b0;

    // Single request from cache 2, zero-wait memory.
    stall_cfg = 0;
    rsp_lat   = 1;
    t = cyc;
    set_addr(2, 15'h1A3);
    bus.req_valid = 4'b0100;
    push_req(2, 15'h1A3, t + 1, t + 3);
    tick(1);
    bus.req_valid = '0;
    drain();

    // Fairness: all four requesting, grants every 5 cycles in order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(15'h100 + i * 15'h11));
    t = cyc;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++)
      push_req(k % N, AW'(15'h100 + (k % N) * 15'h11), t + 5 * k + 1, t + 5 * k + 3);
    tick(22);
    bus.req_valid = '0;
    drain();

    // Memory stalls: ready low 3 cycles, response 4 cycles after acceptance.
    do_reset();
    stall_cfg = 3;
    rsp_lat   = 4;
    t = cyc;
    set_addr(0, 15'h7C01);
    bus.req_valid = 4'b0001;
    push_req(0, 15'h7C01, t + 4, t + 9);
    tick(1);
    bus.req_valid = '0;
    drain();
    stall_cfg = 0;
    rsp_lat   = 1;

    // Stray response while idle must not touch line_data or broadcast.
    @(negedge clk);
    inj_data = {10{16'hDEAD}};
    inj      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_line", bus.line_data, mkline(15'h7C01));
      chk("stray_mreq", LW'(bus.mem_req_valid), '0);
    end
    tick(1);
    t = cyc;
    set_addr(0, 15'h0042);
    bus.req_valid = 4'b0001;
    push_req(0, 15'h0042, t + 1, t + 3);
    tick(1);
    bus.req_valid = '0;
    drain();

    // Requester 1 drops while its fetch is in flight; next grant comes from index 2.
    do_reset();
    rsp_lat = 3;
    set_addr(0, 15'h0AAA);
    set_addr(1, 15'h2B2B);
    set_addr(2, 15'h3CC3);
    set_addr(3, 15'h4DD4);
    t = cyc;
    bus.req_valid = 4'b0010;
    push_req(1, 15'h2B2B, t + 1, t + 5);
    tick(2);
    bus.req_valid = 4'b1101;
    push_req(2, 15'h3CC3, t + 8, t + 12);
    tick(6);
    bus.req_valid = '0;
    drain();

    // Reset during S_WAIT: no broadcast, late response ignored, pointer back to 0.
    rsp_lat = 2;
    set_addr(1, 15'h5E5E);
    t = cyc;
    bus.req_valid = 4'b0010;
    begin
      mr_t m;
      m.addr = 15'h5E5E;
      m.cyc  = t + 1;
      mq.push_back(m);
    end
    tick(1);
    bus.req_valid = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("abort");
    @(negedge clk);
    chk("abort_line_late", bus.line_data, '0);
    chk("abort_bcast_late", LW'(bus.addr_broadcast_valid), '0);
    rsp_lat = 1;
    tick(1);
    t = cyc;
    bus.req_valid = 4'b1111;
    push_req(0, 15'h0AAA, t + 1, t + 3);
    tick(1);
    bus.req_valid = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Shares one backing-memory line-fetch port among `N_REQ` directly mapped broadcast caches. Each cache's miss request (`addr_out_valid`/`addr_out`) is arbitrated round-robin, forwarded to memory, and the returned line is broadcast to all caches on a common `addr_broadcast`/`line_data` bus, so every cache can fill opportunistically. The block sits between the cache array and the memory interface and is the only master of that interface.

## Interface
- `N_REQ`, 4, number of requesting caches (≥2)
- `DWIDTH`, 5, word width
- `BLOCK_WIDTH_BITS`, 5, log2 words per line
- `ADDR_IN_WIDTH`, 20, word address width; `LINE_AW = ADDR_IN_WIDTH-BLOCK_WIDTH_BITS`, `LINE_W = DWIDTH*2**BLOCK_WIDTH_BITS`
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in N_REQ: per-cache `addr_out_valid`.
- `req_addr` in N_REQ*LINE_AW: per-cache `addr_out`; slice i is at `[i*LINE_AW +: LINE_AW]`.
- `req_ready` out N_REQ: per-cache `addr_out_ready`; one-hot pulse.
- `addr_broadcast` out LINE_AW: line address being broadcast.
- `addr_broadcast_valid` out 1: one-cycle broadcast strobe.
- `line_data` out LINE_W: line payload, driving every cache's `data_in`.
- `mem_req_valid` out 1, `mem_req_addr` out LINE_AW, `mem_req_ready` in 1: memory request handshake.
- `mem_rsp_valid` in 1, `mem_rsp_data` in LINE_W: memory response; no back-pressure.

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT, S_BCAST, S_HOLD.
- **S_IDLE:** If `|req_valid`, the round-robin arbiter picks index g. Register `grant_q=g` and `addr_q=req_addr[g]`, advance the pointer to g+1 mod N_REQ, and go to S_REQ. Otherwise stay in S_IDLE.
- **S_REQ:** Drive `mem_req_valid=1` and `mem_req_addr=addr_q`. Leave on the cycle `mem_req_ready=1` and go to S_WAIT.
- **S_WAIT:** When `mem_rsp_valid=1`, set `line_q <= mem_rsp_data` and go to S_BCAST. If `mem_rsp_valid` and `mem_req_ready` are asserted outside their state, they are ignored.
- **S_BCAST (one cycle):**
  - Drive `addr_broadcast_valid=1` and `addr_broadcast=addr_q`.
  - Drive `req_ready[grant_q]=1`; all other `req_ready` bits are 0.
  - Always go to S_HOLD.
- **S_HOLD (one cycle):** `line_data` is held stable. Caches latch the line this cycle, because they write `data_in` the cycle after the ready/broadcast strobe. Then go to S_IDLE.
- `line_data = line_q` at all times. It changes only on the S_WAIT capture edge.
- `addr_broadcast = addr_q` at all times; it is qualified by `addr_broadcast_valid`.
- The request is latched at grant. If requester g drops `req_valid` before S_BCAST, the fetch and broadcast still complete, including `req_ready[g]`. The caches tolerate this.
- Other requesters asking for the same line are served by the broadcast match in the cache, not by this block. They are not granted separately.
- Round-robin pointer: on reset index 0 has top priority. After a grant to g, search order starts at g+1 and wraps modulo N_REQ.
- **Reset values:** FSM=S_IDLE, pointer=0, `grant_q=0`, `addr_q=0`, `line_q=0`. All outputs are 0.
- **Reset mid-operation:** abort immediately. There is no broadcast and no `req_ready` for the in-flight request, and any later memory response is ignored.

## Timing
- Zero-wait memory (`mem_req_ready`=1, response the cycle after acceptance):
  - `req_valid` is seen in S_IDLE at cycle t.
  - `mem_req_valid` is asserted at t+1.
  - `mem_rsp_valid` arrives at t+2.
  - `req_ready`/`addr_broadcast_valid` are asserted at t+3, with `line_data` valid at t+3 and t+4.
  - The block is back in S_IDLE at t+5.
- Minimum grant-to-grant spacing is 5 cycles. Each memory stall cycle adds 1.
- All outputs are decoded from registered state and registers only. There is no combinational input-to-output path.

## Structure
- Package `cache_refill_pkg`: the `State` enum typedef and a `line_aw` helper function/localparam.
- Sub-module `round_robin_arbiter`:
  - Parameter `N`.
  - Inputs: `clk`, `rst`, `req[N]`, `advance`.
  - Output: `grant_idx`, combinational, plus `grant_valid`.
  - The pointer is internal and updates on `advance`.
- Total estimated at 150–250 RTL lines.

## Test plan
- **Single request:** reset, then `req_valid=4'b0100` with `req_addr[2]=15'h1A3` and zero-wait memory. Expected:
  - `mem_req_addr=15'h1A3` 1 cycle later.
  - `req_ready=4'b0100` and `addr_broadcast=15'h1A3` 3 cycles after the request, with `line_data`=rsp data held for 2 cycles.
- **Fairness:** hold `req_valid=4'b1111` with distinct addresses. Grants go in order 0,1,2,3,0, with `req_ready` pulses spaced 5 cycles apart.
- **Memory stalls:** `mem_req_ready` low for 3 cycles, then response 4 cycles after acceptance. `mem_req_valid` and `mem_req_addr` stay stable throughout S_REQ. `req_ready` fires 1 cycle after `mem_rsp_valid`. No spurious broadcast occurs.
- **Stray response:** `mem_rsp_valid` pulsed in S_IDLE with data 0xDEAD…. `line_data` is unchanged and there is no broadcast.
- **Requester drops:** requester 1 granted, then drops `req_valid` in S_WAIT. The broadcast still occurs with `req_ready=4'b0010`, and the next grant goes to index 2.
- **Reset mid-operation:** `rst` asserted in S_WAIT, then a memory response the next cycle. All outputs are 0, there is no broadcast, and the next grant goes to index 0.
